// File: rtl/reg_operand_mgr.sv
// reg_operand_mgr: multi-channel operand register manager (fetch, pointer fetch, write-back, snoop halt).
// Build option REG_BASE_EN: register addresses become base_addr + reg_num.
module reg_operand_mgr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REGN_W = 4,
  parameter int NCH    = 4,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid,
  input  logic [2:0]            op_code,
  input  logic [CH_W-1:0]       op_ch,
  input  logic [REGN_W-1:0]     reg_num,
  input  logic                  is_ptr,
  input  logic [1:0]            reg_flags,
  input  logic                  need_save,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic                  disp_online,
  input  logic                  bus_busy,
  output logic                  read_q,
  output logic                  write_q,
  output logic [ADDR_W-1:0]     bus_addr_o,
  output logic [DATA_W-1:0]     bus_data_o,
  input  logic [ADDR_W-1:0]     bus_addr_i,
  input  logic [DATA_W-1:0]     bus_data_i,
  input  logic                  read_dn,
  input  logic                  write_dn,
  input  logic                  snoop_valid,
  output logic                  rw_halt_o,
  input  logic                  rw_halt_i,
  output logic                  op_done,
  output logic [NCH*DATA_W-1:0] val_o,
  output logic [NCH*DATA_W-1:0] ptr_o
);

  typedef enum logic [2:0] {
    OP_CATCH   = 3'd0,
    OP_PREEXEC = 3'd1,
    OP_READ    = 3'd2,
    OP_READ_P  = 3'd3,
    OP_WRITE   = 3'd4,
    OP_WRITE_P = 3'd5
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e            state, state_nx;
  logic [2:0]        cur_op;
  logic [CH_W-1:0]   cur_ch;
  logic [DATA_W-1:0] val_r   [NCH];
  logic [DATA_W-1:0] ptr_r   [NCH];
  logic [ADDR_W-1:0] raddr_r [NCH];
  logic [NCH-1:0]    ptr_sel;
  logic [NCH-1:0]    save_pend;

  logic [ADDR_W-1:0] raddr_new, addr_new;
  logic [DATA_W-1:0] data_new, ptr_step;
  logic              bus_op, cur_rd, dn_hit, halt_back, issue_ok, snoop_hit;

`ifdef REG_BASE_EN
  assign raddr_new = base_addr + ADDR_W'(reg_num);
`else
  logic unused_base;
  assign unused_base = ^base_addr;
  assign raddr_new   = ADDR_W'(reg_num);
`endif

  assign bus_op    = (op_code == OP_READ) || (op_code == OP_READ_P) ||
                     (op_code == OP_WRITE) || (op_code == OP_WRITE_P);
  assign cur_rd    = (cur_op == OP_READ) || (cur_op == OP_READ_P);
  assign issue_ok  = disp_online && !bus_busy;
  assign dn_hit    = (cur_rd ? read_dn : write_dn) && (bus_addr_i == bus_addr_o);
  assign halt_back = cur_rd && rw_halt_i;
  assign op_done   = (state == S_DONE);

  always_comb begin
    ptr_step = ptr_r[op_ch];
    if (reg_flags == 2'b01)      ptr_step = ptr_r[op_ch] + DATA_W'(1);
    else if (reg_flags == 2'b10) ptr_step = ptr_r[op_ch] - DATA_W'(1);
  end

  // Address and write data are fixed at accept and held on the bus until completion.
  always_comb begin
    addr_new = raddr_new;
    data_new = '0;
    case (op_code)
      OP_READ_P:  addr_new = ADDR_W'(ptr_r[op_ch]);
      OP_WRITE: begin
        if (is_ptr) addr_new = ADDR_W'(ptr_r[op_ch]);
        data_new = val_r[op_ch];
      end
      OP_WRITE_P: data_new = ptr_step;
      default: ;
    endcase
  end

  always_comb begin
    snoop_hit = 1'b0;
    for (int unsigned i = 0; i < NCH; i++)
      if (save_pend[i] && ((raddr_r[i] == bus_addr_i) ||
                           (ptr_sel[i] && (ADDR_W'(ptr_r[i]) == bus_addr_i))))
        snoop_hit = 1'b1;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (op_valid) state_nx = bus_op ? S_ISSUE : S_DONE;
      S_ISSUE: if (issue_ok) state_nx = S_WAIT;
      S_WAIT: begin
        if (halt_back)   state_nx = S_ISSUE;
        else if (dn_hit) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cur_op     <= '0;
      cur_ch     <= '0;
      ptr_sel    <= '0;
      save_pend  <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      bus_addr_o <= '0;
      bus_data_o <= '0;
      rw_halt_o  <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        val_r[i]   <= '0;
        ptr_r[i]   <= '0;
        raddr_r[i] <= '0;
      end
    end else begin
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      rw_halt_o <= snoop_valid && snoop_hit;
      case (state)
        S_IDLE: if (op_valid) begin
          cur_op           <= op_code;
          cur_ch           <= op_ch;
          raddr_r[op_ch]   <= raddr_new;
          ptr_sel[op_ch]   <= is_ptr;
          bus_addr_o       <= bus_op ? addr_new : '0;
          bus_data_o       <= bus_op ? data_new : '0;
          if (op_code == OP_CATCH)   val_r[op_ch]     <= alu_result;
          if (op_code == OP_PREEXEC) save_pend[op_ch] <= (^reg_flags) | need_save;
        end
        S_ISSUE: if (issue_ok) begin
          read_q  <= cur_rd;
          write_q <= !cur_rd;
        end
        S_WAIT: if (!halt_back && dn_hit) begin
          bus_addr_o <= '0;
          bus_data_o <= '0;
          case (cur_op)
            OP_READ: begin
              val_r[cur_ch] <= bus_data_i;
              ptr_r[cur_ch] <= bus_data_i;
            end
            OP_READ_P:  val_r[cur_ch] <= bus_data_i;
            OP_WRITE:   save_pend[cur_ch] <= 1'b0;
            OP_WRITE_P: begin
              ptr_r[cur_ch]     <= bus_data_o;
              save_pend[cur_ch] <= 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    val_o = '0;
    ptr_o = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      val_o[i*DATA_W +: DATA_W] = val_r[i];
      ptr_o[i*DATA_W +: DATA_W] = ptr_r[i];
    end
  end

endmodule
